// File: rtl/xadc_channel_sequencer_pkg.sv
// Shared types and constants for the XADC channel sequencer: FSM state
// encoding, DRP addresses of the two arm-coordinate channels, data widths.
package xadc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        STORE,
        NEXT
    } seq_state_t;

    localparam logic [6:0] VAUX15_ADDR = 7'h1F;
    localparam logic [6:0] VAUX7_ADDR  = 7'h17;

    localparam int RESULT_W = 12;
    localparam int OUT_W    = 8;

endpackage

// File: rtl/xadc_channel_sequencer_if.sv
// DRP bus between the sequencer (master) and the XADC wizard (slave).
interface xadc_channel_sequencer_if;

    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_den, drp_dwe, drp_di, drp_daddr,
        input  drp_do, drp_drdy
    );

    modport slave (
        input  drp_den, drp_dwe, drp_di, drp_daddr,
        output drp_do, drp_drdy
    );

endinterface

// File: rtl/xadc_channel_sequencer_avg4.sv
// Per-channel 4-sample moving average; output and valid appear one cycle
// after the running sum has absorbed the new sample.
module xadc_avg4
    import xadc_seq_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [RESULT_W-1:0] sample,
    output logic [OUT_W-1:0]    avg,
    output logic                valid
);

    logic [RESULT_W-1:0] hist [4];
    logic [RESULT_W+1:0] sum;
    logic                load_d;

    // Running sum swaps the oldest history entry for the new sample
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            sum    <= '0;
            load_d <= 1'b0;
            avg    <= '0;
            valid  <= 1'b0;
        end else begin
            load_d <= load;
            valid  <= load_d;
            if (load) begin
                sum     <= sum + {2'b00, sample} - {2'b00, hist[3]};
                hist[0] <= sample;
                hist[1] <= hist[0];
                hist[2] <= hist[1];
                hist[3] <= hist[2];
            end
            if (load_d) avg <= sum[RESULT_W+1 -: OUT_W];
        end
    end

endmodule

// File: rtl/xadc_channel_sequencer.sv
// Periodic two-channel XADC DRP reader with bounded drdy wait.
// Optional 4-sample averaging per channel when XADC_SEQ_AVG_EN is defined.
module xadc_channel_sequencer
    import xadc_seq_pkg::*;
#(
    parameter logic [6:0] CH0_ADDR  = VAUX15_ADDR,
    parameter logic [6:0] CH1_ADDR  = VAUX7_ADDR,
    parameter int         SWEEP_DIV = 10000,
    parameter int         TIMEOUT   = 63
) (
    input  logic                     clk,
    input  logic                     reset,
    xadc_channel_sequencer_if.master drp,
    output logic [OUT_W-1:0]         xadc_x,
    output logic [OUT_W-1:0]         xadc_y,
    output logic [1:0]               sample_valid,
    output logic                     timeout_err
);

    localparam int SW = $clog2(SWEEP_DIV);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef XADC_SEQ_AVG_EN
    localparam int CAP_W = RESULT_W;
`else
    localparam int CAP_W = OUT_W;
`endif

    seq_state_t       state, state_next;
    logic [SW-1:0]    sweep_cnt;
    logic             sweep_tick;
    logic             sweep_pending;
    logic             ch;
    logic [TW-1:0]    wait_cnt;
    logic             wait_expired;
    logic [CAP_W-1:0] capture;
    logic             store_ch0, store_ch1;
    logic             unused_bits;

    assign sweep_tick   = (sweep_cnt == SW'(SWEEP_DIV - 1));
    assign wait_expired = (wait_cnt == TW'(TIMEOUT));
    assign store_ch0    = (state == STORE) && !ch;
    assign store_ch1    = (state == STORE) && ch;
    assign unused_bits  = ^drp.drp_do[15-CAP_W:0];

    // A tick while a sweep is running is remembered once; later ones are lost
    always_ff @(posedge clk) begin
        if (reset) begin
            sweep_cnt     <= '0;
            sweep_pending <= 1'b0;
        end else begin
            sweep_cnt <= sweep_tick ? '0 : sweep_cnt + SW'(1);
            if (state == IDLE)   sweep_pending <= 1'b0;
            else if (sweep_tick) sweep_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next    = state;
        drp.drp_den   = 1'b0;
        drp.drp_dwe   = 1'b0;
        drp.drp_di    = '0;
        drp.drp_daddr = '0;
        case (state)
            IDLE: if (sweep_tick || sweep_pending) state_next = REQ;
            REQ: begin
                drp.drp_den   = 1'b1;
                drp.drp_daddr = ch ? CH1_ADDR : CH0_ADDR;
                state_next    = WAIT;
            end
            WAIT: begin
                drp.drp_daddr = ch ? CH1_ADDR : CH0_ADDR;
                if (drp.drp_drdy)      state_next = STORE;
                else if (wait_expired) state_next = NEXT;
            end
            STORE:   state_next = NEXT;
            NEXT:    state_next = ch ? IDLE : REQ;
            default: state_next = IDLE;
        endcase
    end

    // drdy wins over expiry on the final wait cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ch          <= 1'b0;
            wait_cnt    <= '0;
            capture     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                REQ: wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + TW'(1);
                    if (drp.drp_drdy)      capture     <= drp.drp_do[15 -: CAP_W];
                    else if (wait_expired) timeout_err <= 1'b1;
                end
                NEXT:    ch <= ~ch;
                default: ;
            endcase
        end
    end

`ifdef XADC_SEQ_AVG_EN
    xadc_avg4 u_avg_x (
        .clk    (clk),
        .reset  (reset),
        .load   (store_ch0),
        .sample (capture),
        .avg    (xadc_x),
        .valid  (sample_valid[0])
    );

    xadc_avg4 u_avg_y (
        .clk    (clk),
        .reset  (reset),
        .load   (store_ch1),
        .sample (capture),
        .avg    (xadc_y),
        .valid  (sample_valid[1])
    );
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            xadc_x       <= '0;
            xadc_y       <= '0;
            sample_valid <= '0;
        end else begin
            sample_valid <= {store_ch1, store_ch0};
            if (store_ch0) xadc_x <= capture;
            if (store_ch1) xadc_y <= capture;
        end
    end
`endif

endmodule

// File: tb/tb_xadc_channel_sequencer.sv
// Randomized bench for xadc_channel_sequencer against a sweep-schedule model.
module tb_xadc_channel_sequencer;
    import xadc_seq_pkg::*;

    localparam int SWEEP_DIV  = 16;
    localparam int TIMEOUT    = 63;
    localparam int NUM_CYCLES = 6000;
`ifdef XADC_SEQ_AVG_EN
    localparam int OUT_LAT = 1;
`else
    localparam int OUT_LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] xadc_x, xadc_y;
    logic [1:0] sample_valid;
    logic       timeout_err;

    xadc_channel_sequencer_if drp ();

    xadc_channel_sequencer #(
        .CH0_ADDR  (7'h1F),
        .CH1_ADDR  (7'h17),
        .SWEEP_DIV (SWEEP_DIV),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .drp          (drp),
        .xadc_x       (xadc_x),
        .xadc_y       (xadc_y),
        .sample_valid (sample_valid),
        .timeout_err  (timeout_err)
    );

    always #50 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: each sweep is two reads; a read with delay d succeeds if 1<=d<=TIMEOUT+1
    int          n;
    bit          active, pending, rst_prev, did_directed_reset;
    int          den0, den1, d0, d1, idle_at, sweep_k, cur_sweep;
    logic [15:0] data0, data1;
    logic [7:0]  x_exp, y_exp;
    logic        err_exp, exp_den;
    logic [6:0]  exp_addr;
    logic [1:0]  exp_sv;
`ifdef XADC_SEQ_AVG_EN
    logic [11:0] hist [2][4];
`endif

    function automatic bit read_ok(int d);
        return d >= 1 && d <= TIMEOUT + 1;
    endfunction

    function automatic int read_span(int d);
        return read_ok(d) ? d + 3 : TIMEOUT + 3;
    endfunction

    function automatic int wait_len(int d);
        return read_ok(d) ? d : TIMEOUT + 1;
    endfunction

    function automatic int random_delay();
        int r;
        r = $urandom_range(0, 15);
        case (r)
            0:       return 0;
            1:       return TIMEOUT + 1;
            2:       return TIMEOUT;
            3:       return 20;
            default: return $urandom_range(1, 8);
        endcase
    endfunction

    task automatic modelReset();
        active  = 0;
        pending = 0;
        x_exp   = '0;
        y_exp   = '0;
        err_exp = 1'b0;
`ifdef XADC_SEQ_AVG_EN
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 4; i++) hist[c][i] = '0;
`endif
    endtask

    task automatic record(input int ch, input logic [15:0] data);
        logic [7:0] v;
`ifdef XADC_SEQ_AVG_EN
        int s;
        for (int i = 3; i > 0; i--) hist[ch][i] = hist[ch][i-1];
        hist[ch][0] = data[15:4];
        s = int'(hist[ch][0]) + int'(hist[ch][1]) + int'(hist[ch][2]) + int'(hist[ch][3]);
        v = 8'(s / 64);
`else
        v = data[15:8];
`endif
        if (ch == 0) x_exp = v;
        else         y_exp = v;
    endtask

    task automatic startSweep(input int s);
        case (sweep_k)
            0:       begin d0 = 2;           d1 = 2; data0 = 16'hA5F0; data1 = 16'h3C00; end
            1:       begin d0 = TIMEOUT + 1; d1 = 3; data0 = 16'hC3A0; data1 = 16'h1234; end
            2:       begin d0 = 0;           d1 = 3; data0 = 16'($urandom); data1 = 16'h5678; end
            3, 4:    begin d0 = 20;          d1 = 20; data0 = 16'($urandom); data1 = 16'($urandom); end
            6:       begin d0 = 2;           d1 = 5; data0 = 16'($urandom); data1 = 16'($urandom); end
            default: begin
                d0 = random_delay(); d1 = random_delay();
                data0 = 16'($urandom); data1 = 16'($urandom);
            end
        endcase
        den0      = s;
        den1      = den0 + read_span(d0);
        idle_at   = den1 + read_span(d1);
        active    = 1;
        cur_sweep = sweep_k;
        sweep_k++;
    endtask

    task automatic modelStep();
        bit tick;
        exp_den  = 1'b0;
        exp_addr = '0;
        exp_sv   = '0;
        if (active) begin
            if (n == den0 || n == den1) exp_den = 1'b1;
            if (n >= den0 && n <= den0 + wait_len(d0)) exp_addr = 7'h1F;
            if (n >= den1 && n <= den1 + wait_len(d1)) exp_addr = 7'h17;
            if (read_ok(d0) && n == den0 + d0 + 2 + OUT_LAT) begin exp_sv[0] = 1'b1; record(0, data0); end
            if (read_ok(d1) && n == den1 + d1 + 2 + OUT_LAT) begin exp_sv[1] = 1'b1; record(1, data1); end
            if (!read_ok(d0) && n == den0 + TIMEOUT + 2) err_exp = 1'b1;
            if (!read_ok(d1) && n == den1 + TIMEOUT + 2) err_exp = 1'b1;
        end
        tick = (n % SWEEP_DIV) == SWEEP_DIV - 1;
        if (active && n == idle_at) active = 0;
        if (!active) begin
            if (tick || pending) begin
                pending = 0;
                startSweep(n + 1);
            end
        end else if (tick) begin
            pending = 1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, n, actual, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("den",          16'(drp.drp_den),   16'(exp_den));
        checkOutput("daddr",        16'(drp.drp_daddr), 16'(exp_addr));
        checkOutput("sample_valid", 16'(sample_valid),  16'(exp_sv));
        checkOutput("xadc_x",       16'(xadc_x),        16'(x_exp));
        checkOutput("xadc_y",       16'(xadc_y),        16'(y_exp));
        checkOutput("timeout_err",  16'(timeout_err),   16'(err_exp));
        checkOutput("dwe",          16'(drp.drp_dwe),   16'h0000);
        checkOutput("di",           drp.drp_di,         16'h0000);
`ifndef XADC_SEQ_AVG_EN
        if (cur_sweep == 0 && n == 16) begin
            checkOutput("lit_den_ch0",   16'(drp.drp_den),   16'h0001);
            checkOutput("lit_addr_ch0",  16'(drp.drp_daddr), 16'h001F);
        end
        if (cur_sweep == 0 && n == 20) begin
            checkOutput("lit_sv_ch0",    16'(sample_valid),  16'h0001);
            checkOutput("lit_x_A5",      16'(xadc_x),        16'h00A5);
        end
        if (cur_sweep == 0 && n == 21) checkOutput("lit_addr_ch1", 16'(drp.drp_daddr), 16'h0017);
        if (cur_sweep == 0 && n == 25) begin
            checkOutput("lit_sv_ch1",    16'(sample_valid),  16'h0002);
            checkOutput("lit_y_3C",      16'(xadc_y),        16'h003C);
        end
        if (cur_sweep == 1 && n == 98) begin
            checkOutput("lit_edge_x",    16'(xadc_x),        16'h00C3);
            checkOutput("lit_edge_err",  16'(timeout_err),   16'h0000);
        end
        if (cur_sweep == 2 && n == 170) checkOutput("lit_err_before", 16'(timeout_err), 16'h0000);
        if (cur_sweep == 2 && n == 171) begin
            checkOutput("lit_err_set",   16'(timeout_err),   16'h0001);
            checkOutput("lit_x_kept",    16'(xadc_x),        16'h00C3);
        end
        if (cur_sweep == 2 && n == 177) checkOutput("lit_y_after_to", 16'(xadc_y), 16'h0056);
`endif
    endtask

    task automatic applyStimulus(input int cyc);
        bit in_wait;
        bit r;
        drp.drp_drdy = 1'b0;
        drp.drp_do   = 16'($urandom);
        if (active) begin
            if (read_ok(d0) && n == den0 + d0) begin
                drp.drp_drdy = 1'b1;
                drp.drp_do   = data0;
            end else if (read_ok(d1) && n == den1 + d1) begin
                drp.drp_drdy = 1'b1;
                drp.drp_do   = data1;
            end
        end
        in_wait = active && ((n > den0 && n <= den0 + wait_len(d0)) ||
                             (n > den1 && n <= den1 + wait_len(d1)));
        if (!in_wait && $urandom_range(0, 5) == 0) drp.drp_drdy = 1'b1;
        r = 0;
        if (cyc < 3) r = 1;
        else if (!did_directed_reset && cur_sweep == 6 && active && n == den1 + 2) begin
            r = 1;
            did_directed_reset = 1;
        end else if (cyc > 1000 && $urandom_range(0, 399) == 0) r = 1;
        reset    = r;
        rst_prev = r;
    endtask

    initial begin
        reset              = 1'b1;
        rst_prev           = 1;
        drp.drp_drdy       = 1'b0;
        drp.drp_do         = '0;
        sweep_k            = 0;
        cur_sweep          = -1;
        did_directed_reset = 0;
        den0 = 0; den1 = 0; d0 = 0; d1 = 0; idle_at = 0;
        n = 0;
        modelReset();
        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);
            if (rst_prev) begin
                modelReset();
                n = 0;
            end else begin
                n++;
            end
            modelStep();
            if (cyc >= 1) checkAll();
            applyStimulus(cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
